// File: rtl/prime_pkg.sv
// prime_pkg: shared FSM state type and default width for the prime scanner.
package prime_pkg;
  localparam int DEF_WIDTH = 11;
  typedef enum logic [2:0] {IDLE, LOAD, TEST, EMIT, DONE} state_t;
endpackage

// File: rtl/prime_scanner_if.sv
// prime_scanner_if: start/result handshake bundle between a consumer (master) and the scanner (slave).
interface prime_scanner_if
  import prime_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = WIDTH
);
  logic                 start;
  logic [WIDTH-1:0]     num_max;
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     number_checked;
  logic                 prime;
  logic [CNT_WIDTH-1:0] number_of_primes;
  logic                 busy;
  logic                 done;
  modport master (
    output start, num_max, res_ready,
    input  res_valid, number_checked, prime, number_of_primes, busy, done
  );
  modport slave (
    input  start, num_max, res_ready,
    output res_valid, number_checked, prime, number_of_primes, busy, done
  );
endinterface

// File: rtl/prime_mod_unit.sv
// prime_mod_unit: n mod d by restoring division, one quotient bit per cycle; rem_valid pulses WIDTH cycles after start.
module prime_mod_unit
  import prime_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             rem_valid,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] a, dv, r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sh;
  assign sh  = {r, a[WIDTH-1]};
  assign rem = r;
  always_ff @(posedge clk) begin
    if (rst) begin
      a         <= '0;
      dv        <= '0;
      r         <= '0;
      cnt       <= '0;
      rem_valid <= 1'b0;
    end else begin
      rem_valid <= 1'b0;
      if (start) begin
        a   <= n;
        dv  <= d;
        r   <= '0;
        cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
        a         <= a << 1;
        r         <= (sh >= {1'b0, dv}) ? WIDTH'(sh - {1'b0, dv}) : sh[WIDTH-1:0];
        cnt       <= cnt - CW'(1);
        rem_valid <= (cnt == CW'(1));
      end
    end
  end
endmodule

// File: rtl/prime_scanner.sv
// prime_scanner: emits one primality beat per candidate 2..num_max using trial division.
// Define PRIME_SCANNER_ODD_SKIP_EN to skip even candidates above 2.
module prime_scanner
  import prime_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  prime_scanner_if.slave bus
);
  state_t               state;
  logic [WIDTH-1:0]     n, d, max_r, rem;
  logic [2*WIDTH-1:0]   sq;
  logic [CNT_WIDTH-1:0] count;
  logic                 is_prime, done_r, div_start, div_wait, rem_valid;
  logic [WIDTH:0]       nxt;
  // one extra bit so the step past 2^WIDTH-1 ends the scan instead of wrapping
`ifdef PRIME_SCANNER_ODD_SKIP_EN
  assign nxt = {1'b0, n} + ((n == WIDTH'(2)) ? (WIDTH+1)'(1) : (WIDTH+1)'(2));
`else
  assign nxt = {1'b0, n} + (WIDTH+1)'(1);
`endif
  prime_mod_unit #(.WIDTH(WIDTH)) u_mod (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .n         (n),
    .d         (d),
    .rem_valid (rem_valid),
    .rem       (rem)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n         <= '0;
      d         <= '0;
      sq        <= '0;
      max_r     <= '0;
      count     <= '0;
      is_prime  <= 1'b0;
      done_r    <= 1'b0;
      div_start <= 1'b0;
      div_wait  <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          max_r  <= bus.num_max;
          count  <= '0;
          done_r <= 1'b0;
          n      <= WIDTH'(2);
          state  <= (bus.num_max < WIDTH'(2)) ? DONE : LOAD;
        end
        LOAD: begin
          d     <= WIDTH'(2);
          sq    <= (2*WIDTH)'(4);
          state <= TEST;
        end
        TEST: if (!div_wait) begin
          if (sq > (2*WIDTH)'(n)) begin
            is_prime <= 1'b1;
            state    <= EMIT;
          end else begin
            div_start <= 1'b1;
            div_wait  <= 1'b1;
          end
        end else if (rem_valid) begin
          div_wait <= 1'b0;
          if (rem == '0) begin
            is_prime <= 1'b0;
            state    <= EMIT;
          end else begin
            // (d+1)^2 = d^2 + 2d + 1
            sq <= sq + (2*WIDTH)'({d, 1'b1});
            d  <= d + WIDTH'(1);
          end
        end
        EMIT: if (bus.res_ready) begin
          count <= count + CNT_WIDTH'(is_prime);
          if (nxt > {1'b0, max_r}) state <= DONE;
          else begin
            n     <= nxt[WIDTH-1:0];
            state <= LOAD;
          end
        end
        DONE: begin
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.res_valid        = (state == EMIT);
  assign bus.number_checked   = n;
  assign bus.prime            = is_prime;
  assign bus.number_of_primes = count;
  assign bus.busy             = state inside {LOAD, TEST, EMIT};
  assign bus.done             = done_r;
endmodule

// File: tb/tb_prime_scanner.sv
// tb_prime_scanner: directed + randomized scans checked against an arithmetic primality model.
module tb_prime_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int last_cyc = 0;
  always #5 clk = ~clk;

  prime_scanner_if bus ();
  prime_scanner_if #(.WIDTH(5), .CNT_WIDTH(5)) bus5 ();

  prime_scanner dut (.clk(clk), .rst(rst), .bus(bus));
  prime_scanner #(.WIDTH(5), .CNT_WIDTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  function automatic bit is_prime(int v);
    if (v < 2) return 1'b0;
    for (int k = 2; k * k <= v; k++) if (v % k == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int prime_count(int m);
    int c = 0;
    for (int v = 2; v <= m; v++) c += int'(is_prime(v));
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input int mx, input int mode);
    int exp_q[$];
    int idx = 0, cyc = 0, stall = 0, model_cnt = 0, pn = 0;
    bit stalled = 1'b0, pp = 1'b0, r;
    for (int v = 2; v <= mx; v++) begin
`ifdef PRIME_SCANNER_ODD_SKIP_EN
      if (v > 2 && v % 2 == 0) continue;
`endif
      exp_q.push_back(v);
    end
    @(negedge clk);
    bus.num_max = 11'(mx);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && cyc < 40000) begin
      if (stalled) begin
        check("hold_valid", 32'(bus.res_valid), 1);
        check("hold_n", 32'(bus.number_checked), pn);
        check("hold_prime", 32'(bus.prime), 32'(pp));
      end
      r = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (mode == 2 && bus.res_valid && bus.number_checked == 7 && stall < 5) begin
        r = 1'b0;
        stall++;
      end
      bus.res_ready = r;
      if (bus.res_valid && r) begin
        check("beat_n", 32'(bus.number_checked), (idx < exp_q.size()) ? exp_q[idx] : -1);
        check("beat_prime", 32'(bus.prime), (idx < exp_q.size()) ? 32'(is_prime(exp_q[idx])) : 0);
        check("running_count", 32'(bus.number_of_primes), model_cnt);
        if (idx < exp_q.size()) model_cnt += int'(is_prime(exp_q[idx]));
        idx++;
      end
      stalled = bus.res_valid && !r;
      pn = int'(bus.number_checked);
      pp = bus.prime;
      @(negedge clk);
      cyc++;
    end
    bus.res_ready = 1'b1;
    last_cyc = cyc;
    check("scan_timeout", 32'(cyc < 40000), 1);
    check("beat_total", idx, exp_q.size());
    check("final_count", 32'(bus.number_of_primes), prime_count(mx));
    check("final_done", 32'(bus.done), 1);
    check("final_busy", 32'(bus.busy), 0);
    check("final_valid", 32'(bus.res_valid), 0);
    if (mode == 2) check("stall_cycles", stall, 5);
  endtask

  initial begin
    int cyc, beats, pr, last;
    bus.start = 1'b0; bus.num_max = '0; bus.res_ready = 1'b1;
    bus5.start = 1'b0; bus5.num_max = '0; bus5.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", 32'(bus.res_valid), 0);
    check("rst_n", 32'(bus.number_checked), 0);
    check("rst_count", 32'(bus.number_of_primes), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);

    scan(10, 0);
    scan(1, 0);
    check("done_latency", 32'(last_cyc <= 2), 1);
    scan(10, 2);

    // reset while n=9 is mid-division, with start raised at the same time
    @(negedge clk);
    bus.num_max = 11'd20;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.busy && !bus.res_valid && bus.number_checked == 9) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_n9", 32'(cyc < 5000), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("mid_rst_valid", 32'(bus.res_valid), 0);
    check("mid_rst_n", 32'(bus.number_checked), 0);
    check("mid_rst_prime", 32'(bus.prime), 0);
    check("mid_rst_count", 32'(bus.number_of_primes), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    @(negedge clk);
    check("start_dropped", 32'(bus.busy), 0);
    scan(5, 0);

    scan(300, 1);
    for (int i = 0; i < 3; i++) scan(int'($urandom_range(0, 80)), 1);

    // narrow instance: scan up to the largest representable value
    @(negedge clk);
    bus5.num_max = 5'd31;
    bus5.start = 1'b1;
    @(negedge clk);
    bus5.start = 1'b0;
    cyc = 0; beats = 0; pr = 0; last = 0;
    while (!bus5.done && cyc < 20000) begin
      if (bus5.res_valid) begin
        beats++;
        pr += int'(bus5.prime);
        last = int'(bus5.number_checked);
      end
      @(negedge clk);
      cyc++;
    end
    check("w5_timeout", 32'(cyc < 20000), 1);
`ifdef PRIME_SCANNER_ODD_SKIP_EN
    check("w5_beats", beats, 16);
`else
    check("w5_beats", beats, 30);
`endif
    check("w5_primes_seen", pr, prime_count(31));
    check("w5_last", last, 31);
    check("w5_count", 32'(bus5.number_of_primes), 11);
    check("w5_done", 32'(bus5.done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prime_scanner.md
PRIME_SCANNER -- requirements
Module: prime_scanner

Interface
REQ-001 SHALL have parameter: WIDTH, 11, candidate/count width in bits.
REQ-002 SHALL have parameter: CNT_WIDTH, WIDTH, width of number_of_primes.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  begin scan; sampled only in IDLE.
REQ-006 SHALL have port: num_max  input  WIDTH  inclusive upper bound; latched on accepted start.
REQ-007 SHALL have port: res_valid  output  1  result beat available.
REQ-008 SHALL have port: res_ready  input  1  consumer accepts beat.
REQ-009 SHALL have port: number_checked  output  WIDTH  candidate of current beat.
REQ-010 SHALL have port: prime  output  1  current candidate is prime.
REQ-011 SHALL have port: number_of_primes  output  CNT_WIDTH  primes accepted so far this scan.
REQ-012 SHALL have port: busy  output  1  scan in progress.
REQ-013 SHALL have port: done  output  1  scan complete; held until next accepted start.

Function
REQ-014 SHALL implement states IDLE, LOAD, TEST, EMIT, DONE.
REQ-015 IDLE + start: latch num_max, clear number_of_primes and done, candidate n=2, go LOAD; if latched num_max<2, go DONE next cycle, no beats.
REQ-016 LOAD: divisor d=2, square sq=4 (2*WIDTH bits), go TEST.
REQ-017 TEST: if sq>n, n is prime -> EMIT; else launch n mod d in sub-module; remainder 0 -> composite -> EMIT; nonzero -> sq=sq+2d+1, d=d+1, repeat.
REQ-018 Primality SHALL be computed by trial division, not lookup; n=2 and n=3 resolve prime with zero divisions.
REQ-019 EMIT: res_valid=1; number_checked and prime stable while res_valid && !res_ready.
REQ-020 Beat accepted when res_valid && res_ready; number_of_primes increments same edge if prime=1.
REQ-021 After acceptance: if n==num_max go DONE, else n=next candidate, go LOAD; no wrap past 2^WIDTH-1.
REQ-022 DONE: done=1, busy=0, res_valid=0, go IDLE same cycle; number_of_primes retained.
REQ-023 busy=1 in LOAD, TEST, EMIT; start ignored while busy.
REQ-024 Beats SHALL be emitted in strictly increasing candidate order, one per candidate.

Reset
REQ-025 rst SHALL force IDLE, all outputs 0, divider idle, on the next posedge, including mid-scan or mid-division.
REQ-026 rst asserted with start SHALL win; start discarded.

Configuration
REQ-027 Macro PRIME_SCANNER_ODD_SKIP_EN defined: candidate sequence 2,3,5,7,... (evens >2 skipped, no beats for them); scan ends at largest emitted candidate <= num_max.
REQ-028 Macro undefined: every integer 2..num_max emitted; number_of_primes identical in both builds.

Structure
REQ-029 Shared package prime_pkg SHALL hold state enum type and default WIDTH constant.
REQ-030 Sub-module prime_mod_unit SHALL compute n mod d by restoring division: start pulse in, rem_valid after exactly WIDTH cycles, remainder WIDTH bits, d=0 never issued.

Verification
REQ-031 num_max=10, res_ready=1 -> beats n=2..10, prime=1 at 2,3,5,7 only; number_of_primes=4; done=1.
REQ-032 num_max=1 -> no res_valid; done=1 within 2 cycles of start; number_of_primes=0.
REQ-033 num_max=1000 -> number_of_primes=168; num_max=2047 -> 309 (beat 2047 prime=0).
REQ-034 res_ready low 5 cycles during n=7 beat -> res_valid, number_checked=7, prime=1 stable; count increments once.
REQ-035 rst pulse during TEST at n=9 -> next cycle all outputs 0, IDLE; fresh start num_max=5 -> count 3.
REQ-036 PRIME_SCANNER_ODD_SKIP_EN, num_max=10 -> beats 2,3,5,7,9 only; number_of_primes=4.
